clk_div_multi: RTL and testbench
================================

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 SHALL have parameter p_channels, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter p_div_width, default 16, bit width of each channel's divisor and counter.
REQ-003 SHALL have parameter p_default_div, default 2, divisor loaded into every channel at reset (0..2^p_div_width-1).
REQ-004 SHALL have port i_clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port i_rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port i_cfg_valid  input  1  divisor write request.
REQ-007 SHALL have port o_cfg_ready  output  1  divisor write can be accepted this cycle.
REQ-008 SHALL have port i_cfg_ch  input  max(1,$clog2(p_channels))  target channel of the write.
REQ-009 SHALL have port i_cfg_div  input  p_div_width  new divisor D for the target channel.
REQ-010 SHALL have port i_sync  input  1  one-cycle phase-align pulse for all channels.
REQ-011 SHALL have port o_clk  output  p_channels  per-channel divided clock, registered.
REQ-012 SHALL have port o_tick  output  p_channels  per-channel one-cycle strobe at each period start, registered.
REQ-013 SHALL have port o_pending  output  p_channels  per-channel flag: shadow divisor awaiting application.

Function
REQ-014 Each channel SHALL hold an active divisor D, a shadow divisor, a pending flag and a p_div_width-bit phase counter.
REQ-015 Channel with D>=2 SHALL run: period exactly D cycles; counter steps 0,1,...,D-1, then wraps to 0.
REQ-016 o_clk[c] SHALL be 1 while counter < ceil(D/2), else 0 (odd D: high one cycle longer than low).
REQ-017 o_tick[c] SHALL be 1 exactly in the cycle the counter equals 0, i.e. coincident with each o_clk[c] rising.
REQ-018 Channel with D=0 or D=1 SHALL be stopped: counter held at 0, o_clk[c]=0, o_tick[c]=0.
REQ-019 Outputs SHALL be registered decodes of the counter's new value; no combinational path from any input to o_clk/o_tick.
REQ-020 o_cfg_ready SHALL be 0 when i_cfg_ch < p_channels and o_pending[i_cfg_ch]=1, else 1 (combinational from i_cfg_ch and pending state).
REQ-021 Write accepted when i_cfg_valid && o_cfg_ready: i_cfg_div captured in the target shadow, pending set next cycle.
REQ-022 Writes with i_cfg_ch >= p_channels SHALL be accepted and discarded, no state change.
REQ-023 Running channel: pending shadow SHALL become active at the wrap edge (counter D-1 -> 0); pending cleared same edge; new period starts with o_tick pulse at new D.
REQ-024 Stopped channel: pending shadow SHALL become active on the edge after the write; if new D>=2, period starts on that edge (o_clk=1, o_tick=1).
REQ-025 Running channel written with D<2 SHALL stop at its next wrap edge, outputs 0 from that edge.
REQ-026 i_sync=1 SHALL, on that edge, apply all pending shadows (including a write accepted that same cycle), clear all pending, and force every running channel's counter to 0 (o_clk=1, o_tick=1).
REQ-027 Counter and comparisons SHALL be unsigned p_div_width wide; D=2^p_div_width-1 SHALL work without overflow.

Reset
REQ-028 While i_rst=1: active and shadow divisors = p_default_div, pending = 0, counters = 0, o_clk = 0, o_tick = 0; i_cfg_valid and i_sync ignored.
REQ-029 First edge with i_rst=0 SHALL start a period on every running channel: o_clk=1, o_tick=1 for that cycle.
REQ-030 Reset asserted mid-period or with a write pending SHALL discard the pending write and restore REQ-028 state on the next edge.

Verification
REQ-031 Defaults, release reset -> all o_clk toggle every cycle (1,0,1,0), o_tick on every high cycle, o_pending=0.
REQ-032 Write D=5 to ch1 while running D=2 -> ch1 switches at its wrap; then o_clk pattern 1,1,1,0,0 repeating, o_tick every 5 cycles; o_pending[1] high exactly until the switch.
REQ-033 ch2 write D=0, then second write on ch2 while pending -> o_cfg_ready=0 for ch2 only; after stop ch2 outputs stay 0; write D=3 -> period starts next edge, pattern 1,1,0.
REQ-034 ch0 D=3, ch3 D=6, random offset, pulse i_sync -> both o_tick pulse same cycle; o_tick[3] thereafter coincides with every second o_tick[0].
REQ-035 p_div_width=4, write D=15 -> period 15, high 8 / low 7; write i_cfg_ch=7 with p_channels=4 -> accepted, no channel changes.
REQ-036 Assert i_rst for 1 cycle mid-period with ch1 pending -> next edge all outputs 0, pending cleared; following edge all channels tick with D=p_default_div.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with shadowed divisor updates.
// Each channel produces a registered divided clock and a period-start tick.
module clk_div_multi #(
  parameter int p_channels    = 4,
  parameter int p_div_width   = 16,
  parameter int p_default_div = 2,
  localparam int c_cw = (p_channels > 1) ? $clog2(p_channels) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cfg_valid,
  output logic                   o_cfg_ready,
  input  logic [c_cw-1:0]        i_cfg_ch,
  input  logic [p_div_width-1:0] i_cfg_div,
  input  logic                   i_sync,
  output logic [p_channels-1:0]  o_clk,
  output logic [p_channels-1:0]  o_tick,
  output logic [p_channels-1:0]  o_pending
);

  localparam logic [p_div_width-1:0] c_zero = {p_div_width{1'b0}};
  localparam logic [p_div_width-1:0] c_one  = {{(p_div_width-1){1'b0}}, 1'b1};
  localparam logic [p_div_width-1:0] c_def  = p_div_width'(p_default_div);

  logic [p_div_width-1:0] act_r [p_channels];
  logic [p_div_width-1:0] sh_r  [p_channels];
  logic [p_div_width-1:0] cnt_r [p_channels];
  logic [p_channels-1:0]  pend_r;
  logic [p_channels-1:0]  clk_r;
  logic [p_channels-1:0]  tick_r;
  logic                   restart_r;

  logic [p_div_width-1:0] act_s [p_channels];
  logic [p_div_width-1:0] sh_s  [p_channels];
  logic [p_div_width-1:0] cnt_s [p_channels];
  logic [p_channels-1:0]  pend_s;
  logic [p_channels-1:0]  clk_s;
  logic [p_channels-1:0]  tick_s;
  logic [p_channels-1:0]  hit_s;
  logic                   ready_s;
  logic                   accept_s;

  // A divisor of 0 or 1 means the channel is stopped.
  function automatic logic is_run(input logic [p_div_width-1:0] d);
    return (d[p_div_width-1:1] != {(p_div_width-1){1'b0}});
  endfunction

  // ceil(d/2) without widening: the result never exceeds 2^(w-1).
  function automatic logic [p_div_width-1:0] half_up(input logic [p_div_width-1:0] d);
    return (d >> 1) + {{(p_div_width-1){1'b0}}, d[0]};
  endfunction

  // Write handshake: blocked only while the addressed in-range channel is pending.
  always_comb begin
    ready_s = 1'b1;
    for (int c = 0; c < p_channels; c++) begin
      if ((int'(i_cfg_ch) == c) && pend_r[c]) begin
        ready_s = 1'b0;
      end else begin
        ready_s = ready_s;
      end
    end
    accept_s = i_cfg_valid && ready_s;
  end

  // Per-channel next state: shadow capture, divisor application, counter and output decode.
  always_comb begin
    for (int c = 0; c < p_channels; c++) begin
      hit_s[c]  = accept_s && (int'(i_cfg_ch) == c);
      act_s[c]  = act_r[c];
      sh_s[c]   = hit_s[c] ? i_cfg_div : sh_r[c];
      pend_s[c] = pend_r[c] | hit_s[c];
      cnt_s[c]  = cnt_r[c];
      if (i_sync) begin
        if (hit_s[c]) begin
          act_s[c] = i_cfg_div;
        end else if (pend_r[c]) begin
          act_s[c] = sh_r[c];
        end else begin
          act_s[c] = act_r[c];
        end
        pend_s[c] = 1'b0;
        cnt_s[c]  = c_zero;
      end else if (restart_r) begin
        cnt_s[c] = c_zero;
      end else if (!is_run(act_r[c])) begin
        // Stopped channels pick up a pending divisor right away.
        if (pend_r[c]) begin
          act_s[c]  = sh_r[c];
          pend_s[c] = 1'b0;
        end else begin
          act_s[c] = act_r[c];
        end
        cnt_s[c] = c_zero;
      end else if (cnt_r[c] == (act_r[c] - c_one)) begin
        if (pend_r[c]) begin
          act_s[c]  = sh_r[c];
          pend_s[c] = 1'b0;
        end else begin
          act_s[c] = act_r[c];
        end
        cnt_s[c] = c_zero;
      end else begin
        cnt_s[c] = cnt_r[c] + c_one;
      end
      if (!is_run(act_s[c])) begin
        cnt_s[c]  = c_zero;
        clk_s[c]  = 1'b0;
        tick_s[c] = 1'b0;
      end else begin
        clk_s[c]  = (cnt_s[c] < half_up(act_s[c]));
        tick_s[c] = (cnt_s[c] == c_zero);
      end
    end
  end

  // State and output registers; restart_r forces a fresh period on the first edge out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < p_channels; c++) begin
        act_r[c] <= c_def;
        sh_r[c]  <= c_def;
        cnt_r[c] <= c_zero;
      end
      pend_r    <= {p_channels{1'b0}};
      clk_r     <= {p_channels{1'b0}};
      tick_r    <= {p_channels{1'b0}};
      restart_r <= 1'b1;
    end else begin
      for (int c = 0; c < p_channels; c++) begin
        act_r[c] <= act_s[c];
        sh_r[c]  <= sh_s[c];
        cnt_r[c] <= cnt_s[c];
      end
      pend_r    <= pend_s;
      clk_r     <= clk_s;
      tick_r    <= tick_s;
      restart_r <= 1'b0;
    end
  end

  assign o_cfg_ready = ready_s;
  assign o_clk       = clk_r;
  assign o_tick      = tick_r;
  assign o_pending   = pend_r;

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a behavioural model queues expected
// outputs as each cycle's stimulus is driven; they are popped after the edge.
module tb_clk_div_multi;

  localparam int NCH = 5;
  localparam int DW  = 4;
  localparam int CW  = 3;

  logic          clk;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch;
  logic [DW-1:0] cfg_div;
  logic          sync;
  logic [NCH-1:0] o_clk;
  logic [NCH-1:0] o_tick;
  logic [NCH-1:0] o_pending;

  clk_div_multi #(.p_channels(NCH), .p_div_width(DW), .p_default_div(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
    .i_cfg_ch(cfg_ch), .i_cfg_div(cfg_div), .i_sync(sync),
    .o_clk(o_clk), .o_tick(o_tick), .o_pending(o_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] ck;
    logic [NCH-1:0] tk;
    logic [NCH-1:0] pd;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;

  int m_act[NCH];
  int m_sh[NCH];
  int m_cnt[NCH];
  bit m_pend[NCH];
  bit m_restart;
  int tick0_cnt;
  int tick3_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic bit m_ready(input int ch);
    if (ch < NCH) return !m_pend[ch];
    return 1'b1;
  endfunction

  // Advance the reference model by one clock edge and queue the expected outputs.
  task automatic model_edge(input bit r, input bit v, input int ch, input int dv, input bit s);
    exp_t e;
    e = '0;
    if (r) begin
      for (int c = 0; c < NCH; c++) begin
        m_act[c] = 2; m_sh[c] = 2; m_cnt[c] = 0; m_pend[c] = 1'b0;
      end
      m_restart = 1'b1;
    end else begin
      bit acc;
      acc = v && m_ready(ch);
      for (int c = 0; c < NCH; c++) begin
        bit hit;
        bit old_pend;
        int nd;
        int nc;
        hit = acc && (ch == c);
        old_pend = m_pend[c];
        nd = m_act[c];
        nc = m_cnt[c] + 1;
        if (hit) begin
          m_sh[c] = dv;
          m_pend[c] = 1'b1;
        end
        if (s) begin
          if (old_pend || hit) nd = m_sh[c];
          m_pend[c] = 1'b0;
          nc = 0;
        end else if (m_restart) begin
          nc = 0;
        end else if (m_act[c] < 2) begin
          if (old_pend) begin nd = m_sh[c]; m_pend[c] = 1'b0; end
          nc = 0;
        end else if (m_cnt[c] == m_act[c] - 1) begin
          if (old_pend) begin nd = m_sh[c]; m_pend[c] = 1'b0; end
          nc = 0;
        end
        if (nd < 2) nc = 0;
        m_act[c] = nd;
        m_cnt[c] = nc;
        e.ck[c] = (nd >= 2) && (nc < (nd + 1) / 2);
        e.tk[c] = (nd >= 2) && (nc == 0);
      end
      m_restart = 1'b0;
    end
    for (int c = 0; c < NCH; c++) e.pd[c] = m_pend[c];
    exp_q.push_back(e);
  endtask

  // One clock cycle: drive at negedge, check handshake, model, pop after the edge.
  task automatic cyc(input bit r, input bit v, input int ch, input int dv, input bit s);
    exp_t e;
    @(negedge clk);
    rst = r; cfg_valid = v; cfg_ch = CW'(ch); cfg_div = DW'(dv); sync = s;
    #1;
    check("cfg_ready", {31'd0, cfg_ready}, {31'd0, m_ready(ch)});
    model_edge(r, v, ch, dv, s);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("o_clk", {27'd0, o_clk}, {27'd0, e.ck});
      check("o_tick", {27'd0, o_tick}, {27'd0, e.tk});
      check("o_pending", {27'd0, o_pending}, {27'd0, e.pd});
    end
    if (o_tick[0]) tick0_cnt++;
    if (o_tick[3]) tick3_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int off;
    n_tests = 0; n_fail = 0; tick0_cnt = 0; tick3_cnt = 0;
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; sync = 1'b0;
    m_restart = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      m_act[c] = 2; m_sh[c] = 2; m_cnt[c] = 0; m_pend[c] = 1'b0;
    end

    // Reset with ignored write and sync requests.
    cyc(1'b1, 1'b0, 0, 0, 1'b0);
    cyc(1'b1, 1'b1, 1, 7, 1'b1);
    cyc(1'b1, 1'b0, 0, 0, 1'b0);
    check("reset_clk", {27'd0, o_clk}, 32'd0);

    // Default divide-by-2 after release.
    cyc(1'b0, 1'b0, 0, 0, 1'b0);
    check("release_clk", {27'd0, o_clk}, 32'h1f);
    check("release_tick", {27'd0, o_tick}, 32'h1f);
    idle(1);
    check("release_low", {27'd0, o_clk}, 32'h00);
    idle(4);

    // ch1 to D=5 while running D=2.
    cyc(1'b0, 1'b1, 1, 5, 1'b0);
    idle(16);

    // ch2 stop, blocked second write, then restart at D=3.
    cyc(1'b0, 1'b1, 2, 0, 1'b0);
    cyc(1'b0, 1'b1, 2, 7, 1'b0);
    cyc(1'b0, 1'b1, 3, 2, 1'b0);
    idle(6);
    check("ch2_stopped", {31'd0, o_clk[2]}, 32'd0);
    cyc(1'b0, 1'b1, 2, 3, 1'b0);
    idle(1);
    check("ch2_start", {30'd0, o_clk[2], o_tick[2]}, 32'd3);
    idle(7);

    // ch0 D=3, ch3 D=6, random offset, then sync.
    cyc(1'b0, 1'b1, 0, 3, 1'b0);
    cyc(1'b0, 1'b1, 3, 6, 1'b0);
    off = $urandom_range(2, 9);
    idle(off);
    cyc(1'b0, 1'b0, 0, 0, 1'b1);
    check("sync_ticks", {30'd0, o_tick[3], o_tick[0]}, 32'd3);
    tick0_cnt = 0; tick3_cnt = 0;
    idle(18);
    check("tick_ratio", tick0_cnt, 32'd6);
    check("tick3_count", tick3_cnt, 32'd3);

    // Widest divisor on ch4, then out-of-range write.
    cyc(1'b0, 1'b1, 4, 15, 1'b0);
    idle(32);
    cyc(1'b0, 1'b1, 7, 9, 1'b0);
    idle(5);

    // Sync with a same-cycle write.
    cyc(1'b0, 1'b1, 2, 4, 1'b1);
    idle(9);

    // Running ch0 written to D=1 stops at its wrap.
    cyc(1'b0, 1'b1, 0, 1, 1'b0);
    idle(6);

    // Reset mid-period with ch1 pending.
    cyc(1'b0, 1'b1, 1, 3, 1'b0);
    idle(1);
    cyc(1'b1, 1'b0, 0, 0, 1'b0);
    check("midrst_pend", {27'd0, o_pending}, 32'd0);
    cyc(1'b0, 1'b0, 0, 0, 1'b0);
    check("midrst_tick", {27'd0, o_tick}, 32'h1f);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
